btb_predictor: RTL and testbench
================================

BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 5, log2 of the entry count (32 entries).
REQ-002 SHALL have ports, one per line, as follows:
- clk  in  1  sole clock, rising edge
- rstn  in  1  asynchronous active-low reset
- if1_pc  in  32  IF1 fetch PC
- if1_valid  in  1  IF1 PC is valid
- stall  in  1  IF1/IF2 pipeline register hold
- flush  in  1  kill the IF2-bound prediction
- pred_npc  out  32  combinational next-PC for the PC mux
- brtype_pcpre  out  34  registered {type[1:0], predicted target} to IF2
- pred_valid  out  1  registered, brtype_pcpre valid
- pd_upd_en  in  1  predecoder correction strobe
- pd_pc  in  32  PC being corrected
- pd_type  in  2  decoded type
- pd_target  in  32  corrected target
- ex_upd_en  in  1  EX branch resolve strobe
- ex_pc  in  32  resolved branch PC
- ex_type  in  2  resolved type
- ex_taken  in  1  branch actually taken
- ex_target  in  32  actual target

Function
REQ-003 SHALL be direct-mapped: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
REQ-004 Each entry SHALL hold valid, tag, type[1:0] (00 none, 01 cond/b, 10 bl, 11 jirl), target[31:0] and ctr[1:0].
REQ-005 Lookup SHALL be a combinational read: hit = if1_valid & valid[idx] & tag match & type!=00.
REQ-006 Taken SHALL be: hit & (type==10 | type==11 | (type==01 & ctr[1])).
REQ-007 pred_npc SHALL be target when taken, else if1_pc+4, wrapping modulo 2^32.
REQ-008 On each clk edge with ~stall, SHALL register brtype_pcpre = {taken?type:00, pred_npc} and pred_valid = if1_valid & ~flush.
REQ-009 With stall=1 and flush=0, brtype_pcpre and pred_valid SHALL hold.
REQ-010 flush SHALL clear pred_valid to 0 at the next edge regardless of stall; brtype_pcpre SHALL be set to {00, if1_pc+4}.
REQ-011 A PD update SHALL write the entry at idx(pd_pc): valid=1, tag, type=pd_type, target=pd_target, ctr=2'b10.
REQ-012 A PD update with pd_type==00 SHALL instead clear valid (false-jump removal).
REQ-013 An EX update on a tag hit SHALL saturate ctr toward 11 if ex_taken, else toward 00, and SHALL write target=ex_target when ex_taken.
REQ-014 An EX update on a miss with ex_taken=1 SHALL allocate: valid=1, type=ex_type, target=ex_target, ctr=2'b10.
REQ-015 An EX update on a miss with ex_taken=0 SHALL leave the entry unchanged.
REQ-016 ex_type==00 SHALL never allocate.
REQ-017 When the PD and EX updates target the same index in one cycle, EX SHALL win and the PD write SHALL be dropped.
REQ-018 When they target different indices, both SHALL commit.
REQ-019 Writes SHALL take effect at the clock edge; a same-cycle lookup of a written index SHALL see the old contents (no bypass).
REQ-020 Updates SHALL proceed independently of stall and flush.
REQ-021 Latency: IF1 lookup to IF2 brtype_pcpre SHALL be exactly one unstalled cycle; table update to visible lookup SHALL be one cycle.

Reset
REQ-022 On rstn=0, asynchronously: all valid=0, all ctr=2'b01, brtype_pcpre=34'd0, pred_valid=0.
REQ-023 Tag, type and target storage SHALL be don't-care under reset (may use RAM without reset).
REQ-024 pred_npc SHALL follow if1_pc+4 while the table is empty.
REQ-025 Reset asserted mid-update SHALL discard the update.

Verification
REQ-026 Cold lookup: after reset, if1_pc=0x1C000000, if1_valid=1 -> pred_npc=0x1C000004; next edge brtype_pcpre={00,0x1C000004}, pred_valid=1.
REQ-027 PD allocate then hit: pd_upd_en with pd_pc=0x1C000010, type 10, target 0x1C000100; next cycle if1_pc=0x1C000010 -> pred_npc=0x1C000100; then brtype_pcpre={10,0x1C000100}.
REQ-028 Counter training: after an EX allocation of type 01 at 0x80 (ctr=10), two not-taken EX updates -> ctr=00 and lookup of 0x80 gives pred_npc=0x84 with type 00; two taken updates -> ctr=10 and prediction is taken again.
REQ-029 Collision: same cycle PD (pc 0x40, target 0x100) and EX (pc 0x40, taken, target 0x200) -> entry target=0x200; PD aliasing at pc 0x1040 (same index, different tag) also loses.
REQ-030 Stall/flush: stall=1 for 3 cycles -> outputs hold; flush=1 with stall=1 -> pred_valid=0 next edge; pd_type=00 on a valid entry -> lookup misses next cycle.
REQ-031 Async reset: drop rstn between edges while an entry is valid -> pred_valid=0 immediately, and later lookups miss.

Source files
------------

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters: combinational IF1
// lookup, registered IF2 prediction, and predecoder/EX update ports.
module btb_predictor #(
    parameter int IDX_W = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] if1_pc,
    input  logic        if1_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] pred_npc,
    output logic [33:0] brtype_pcpre,
    output logic        pred_valid,
    input  logic        pd_upd_en,
    input  logic [31:0] pd_pc,
    input  logic [1:0]  pd_type,
    input  logic [31:0] pd_target,
    input  logic        ex_upd_en,
    input  logic [31:0] ex_pc,
    input  logic [1:0]  ex_type,
    input  logic        ex_taken,
    input  logic [31:0] ex_target
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    logic [ENTRIES-1:0]      valid;
    logic [ENTRIES-1:0][1:0] ctr;
    logic [TAG_W-1:0]        tag_mem    [ENTRIES];
    logic [1:0]              type_mem   [ENTRIES];
    logic [31:0]             target_mem [ENTRIES];

    logic [IDX_W-1:0] lk_idx, pd_idx, ex_idx;
    logic [TAG_W-1:0] lk_tag, pd_tag, ex_tag;
    logic [1:0]       lk_type, lk_ctr, ex_ctr, ex_ctr_nxt;
    logic             hit, taken, ex_hit, ex_alloc, ex_train, pd_we;
    logic [31:0]      pc_plus4;

    assign lk_idx = if1_pc[IDX_W+1:2];
    assign lk_tag = if1_pc[31:IDX_W+2];
    assign pd_idx = pd_pc[IDX_W+1:2];
    assign pd_tag = pd_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];

    // Lookup reads the pre-edge table; writes never bypass into it.
    assign lk_type  = type_mem[lk_idx];
    assign lk_ctr   = ctr[lk_idx];
    assign hit      = if1_valid & valid[lk_idx] & (tag_mem[lk_idx] == lk_tag) & (lk_type != 2'b00);
    assign taken    = hit & (lk_type[1] | (lk_type == 2'b01 & lk_ctr[1]));
    assign pc_plus4 = if1_pc + 32'd4;
    assign pred_npc = taken ? target_mem[lk_idx] : pc_plus4;

    assign ex_hit     = valid[ex_idx] & (tag_mem[ex_idx] == ex_tag);
    assign ex_alloc   = ex_upd_en & ~ex_hit & ex_taken & (ex_type != 2'b00);
    assign ex_train   = ex_upd_en & ex_hit;
    assign ex_ctr     = ctr[ex_idx];
    assign ex_ctr_nxt = ex_taken ? ((ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'd1)
                                 : ((ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'd1);
    // EX owns the index whenever both ports hit the same set this cycle.
    assign pd_we      = pd_upd_en & ~(ex_upd_en & (ex_idx == pd_idx));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= '0;
            ctr   <= {ENTRIES{2'b01}};
        end else begin
            if (pd_we) begin
                valid[pd_idx] <= (pd_type != 2'b00);
                if (pd_type != 2'b00) ctr[pd_idx] <= 2'b10;
            end
            if (ex_alloc) begin
                valid[ex_idx] <= 1'b1;
                ctr[ex_idx]   <= 2'b10;
            end else if (ex_train) begin
                ctr[ex_idx] <= ex_ctr_nxt;
            end
        end
    end

    // Payload storage carries no reset; valid gates every use of it.
    always_ff @(posedge clk) begin
        if (pd_we && pd_type != 2'b00) begin
            tag_mem[pd_idx]    <= pd_tag;
            type_mem[pd_idx]   <= pd_type;
            target_mem[pd_idx] <= pd_target;
        end
        if (ex_alloc) begin
            tag_mem[ex_idx]    <= ex_tag;
            type_mem[ex_idx]   <= ex_type;
            target_mem[ex_idx] <= ex_target;
        end else if (ex_train && ex_taken) begin
            target_mem[ex_idx] <= ex_target;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            brtype_pcpre <= 34'd0;
            pred_valid   <= 1'b0;
        end else if (flush) begin
            brtype_pcpre <= {2'b00, pc_plus4};
            pred_valid   <= 1'b0;
        end else if (!stall) begin
            brtype_pcpre <= {(taken ? lk_type : 2'b00), pred_npc};
            pred_valid   <= if1_valid;
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor.
module tb_btb_predictor;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] if1_pc;
    logic        if1_valid, stall, flush;
    logic [31:0] pred_npc;
    logic [33:0] brtype_pcpre;
    logic        pred_valid;
    logic        pd_upd_en;
    logic [31:0] pd_pc, pd_target;
    logic [1:0]  pd_type;
    logic        ex_upd_en, ex_taken;
    logic [31:0] ex_pc, ex_target;
    logic [1:0]  ex_type;

    int checks = 0;
    int failures = 0;

    btb_predictor #(.IDX_W(5)) dut (
        .clk(clk), .rstn(rstn), .if1_pc(if1_pc), .if1_valid(if1_valid),
        .stall(stall), .flush(flush), .pred_npc(pred_npc),
        .brtype_pcpre(brtype_pcpre), .pred_valid(pred_valid),
        .pd_upd_en(pd_upd_en), .pd_pc(pd_pc), .pd_type(pd_type), .pd_target(pd_target),
        .ex_upd_en(ex_upd_en), .ex_pc(ex_pc), .ex_type(ex_type),
        .ex_taken(ex_taken), .ex_target(ex_target)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pd_wr(input logic [31:0] pc, input logic [1:0] t, input logic [31:0] tgt);
        pd_upd_en = 1'b1; pd_pc = pc; pd_type = t; pd_target = tgt;
        step();
        pd_upd_en = 1'b0;
    endtask

    task automatic ex_wr(input logic [31:0] pc, input logic [1:0] t, input logic tk, input logic [31:0] tgt);
        ex_upd_en = 1'b1; ex_pc = pc; ex_type = t; ex_taken = tk; ex_target = tgt;
        step();
        ex_upd_en = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        if1_pc = 32'h1C000000; if1_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        pd_upd_en = 1'b0; pd_pc = '0; pd_type = '0; pd_target = '0;
        ex_upd_en = 1'b0; ex_pc = '0; ex_type = '0; ex_taken = 1'b0; ex_target = '0;
        #3;
        checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pred_valid); end
        checks++; if (brtype_pcpre !== 34'd0) begin failures++; $display("FAIL reset_brtype got=%h exp=0", brtype_pcpre); end
        step(); step();
        checks++; if (brtype_pcpre !== 34'd0) begin failures++; $display("FAIL reset_hold got=%h exp=0", brtype_pcpre); end
        rstn = 1'b1;
    endtask

    task automatic test_cold_lookup;
        if1_pc = 32'h1C000000; if1_valid = 1'b1;
        #1;
        checks++; if (pred_npc !== 32'h1C000004) begin failures++; $display("FAIL cold_npc got=%h exp=1c000004", pred_npc); end
        step();
        checks++; if (brtype_pcpre !== {2'b00, 32'h1C000004}) begin failures++; $display("FAIL cold_brtype got=%h exp=%h", brtype_pcpre, {2'b00, 32'h1C000004}); end
        checks++; if (pred_valid !== 1'b1) begin failures++; $display("FAIL cold_valid got=%b exp=1", pred_valid); end
    endtask

    task automatic test_pd_alloc;
        pd_upd_en = 1'b1; pd_pc = 32'h1C000010; pd_type = 2'b10; pd_target = 32'h1C000100;
        if1_pc = 32'h1C000010;
        #1;
        checks++; if (pred_npc !== 32'h1C000014) begin failures++; $display("FAIL pd_nobypass got=%h exp=1c000014", pred_npc); end
        step();
        pd_upd_en = 1'b0;
        checks++; if (brtype_pcpre !== {2'b00, 32'h1C000014}) begin failures++; $display("FAIL pd_old_brtype got=%h exp=%h", brtype_pcpre, {2'b00, 32'h1C000014}); end
        #1;
        checks++; if (pred_npc !== 32'h1C000100) begin failures++; $display("FAIL pd_hit_npc got=%h exp=1c000100", pred_npc); end
        step();
        checks++; if (brtype_pcpre !== {2'b10, 32'h1C000100}) begin failures++; $display("FAIL pd_hit_brtype got=%h exp=%h", brtype_pcpre, {2'b10, 32'h1C000100}); end
    endtask

    task automatic test_counter;
        if1_pc = 32'h80;
        ex_wr(32'h80, 2'b01, 1'b1, 32'h300);
        #1;
        checks++; if (pred_npc !== 32'h300) begin failures++; $display("FAIL ctr_alloc got=%h exp=300", pred_npc); end
        ex_wr(32'h80, 2'b01, 1'b0, 32'h999);
        ex_wr(32'h80, 2'b01, 1'b0, 32'h999);
        checks++; if (pred_npc !== 32'h84) begin failures++; $display("FAIL ctr_nt2_npc got=%h exp=84", pred_npc); end
        step();
        checks++; if (brtype_pcpre !== {2'b00, 32'h84}) begin failures++; $display("FAIL ctr_nt2_brtype got=%h exp=%h", brtype_pcpre, {2'b00, 32'h84}); end
        ex_wr(32'h80, 2'b01, 1'b0, 32'h999);
        ex_wr(32'h80, 2'b01, 1'b1, 32'h300);
        checks++; if (pred_npc !== 32'h84) begin failures++; $display("FAIL ctr_floor got=%h exp=84", pred_npc); end
        ex_wr(32'h80, 2'b01, 1'b1, 32'h300);
        checks++; if (pred_npc !== 32'h300) begin failures++; $display("FAIL ctr_retrain got=%h exp=300", pred_npc); end
        step();
        checks++; if (brtype_pcpre !== {2'b01, 32'h300}) begin failures++; $display("FAIL ctr_retrain_brtype got=%h exp=%h", brtype_pcpre, {2'b01, 32'h300}); end
        ex_wr(32'h80, 2'b01, 1'b1, 32'h300);
        ex_wr(32'h80, 2'b01, 1'b1, 32'h300);
        ex_wr(32'h80, 2'b01, 1'b0, 32'h999);
        checks++; if (pred_npc !== 32'h300) begin failures++; $display("FAIL ctr_ceiling got=%h exp=300", pred_npc); end
        ex_wr(32'h80, 2'b01, 1'b0, 32'h999);
        checks++; if (pred_npc !== 32'h84) begin failures++; $display("FAIL ctr_down got=%h exp=84", pred_npc); end
    endtask

    task automatic test_collision;
        pd_upd_en = 1'b1; pd_pc = 32'h40; pd_type = 2'b10; pd_target = 32'h100;
        ex_wr(32'h40, 2'b11, 1'b1, 32'h200);
        pd_upd_en = 1'b0;
        if1_pc = 32'h40;
        #1;
        checks++; if (pred_npc !== 32'h200) begin failures++; $display("FAIL coll_same got=%h exp=200", pred_npc); end
        step();
        checks++; if (brtype_pcpre !== {2'b11, 32'h200}) begin failures++; $display("FAIL coll_type got=%h exp=%h", brtype_pcpre, {2'b11, 32'h200}); end
        pd_upd_en = 1'b1; pd_pc = 32'h1040; pd_type = 2'b10; pd_target = 32'h100;
        ex_wr(32'h40, 2'b11, 1'b1, 32'h240);
        pd_upd_en = 1'b0;
        checks++; if (pred_npc !== 32'h240) begin failures++; $display("FAIL coll_alias_ex got=%h exp=240", pred_npc); end
        if1_pc = 32'h1040; #1;
        checks++; if (pred_npc !== 32'h1044) begin failures++; $display("FAIL coll_alias_pd got=%h exp=1044", pred_npc); end
        pd_upd_en = 1'b1; pd_pc = 32'h60; pd_type = 2'b10; pd_target = 32'h500;
        ex_wr(32'hA0, 2'b10, 1'b1, 32'h600);
        pd_upd_en = 1'b0;
        if1_pc = 32'h60; #1;
        checks++; if (pred_npc !== 32'h500) begin failures++; $display("FAIL both_pd got=%h exp=500", pred_npc); end
        if1_pc = 32'hA0; #1;
        checks++; if (pred_npc !== 32'h600) begin failures++; $display("FAIL both_ex got=%h exp=600", pred_npc); end
        ex_wr(32'h2040, 2'b01, 1'b0, 32'h777);
        if1_pc = 32'h40; #1;
        checks++; if (pred_npc !== 32'h240) begin failures++; $display("FAIL ex_miss_nt got=%h exp=240", pred_npc); end
        ex_wr(32'h1C, 2'b00, 1'b1, 32'h700);
        if1_pc = 32'h1C; #1;
        checks++; if (pred_npc !== 32'h20) begin failures++; $display("FAIL ex_type0 got=%h exp=20", pred_npc); end
    endtask

    task automatic test_stall_flush;
        if1_pc = 32'h1C000010; if1_valid = 1'b1;
        step();
        checks++; if (brtype_pcpre !== {2'b10, 32'h1C000100}) begin failures++; $display("FAIL sf_setup got=%h exp=%h", brtype_pcpre, {2'b10, 32'h1C000100}); end
        stall = 1'b1; if1_pc = 32'h0; if1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (brtype_pcpre !== {2'b10, 32'h1C000100}) begin failures++; $display("FAIL stall_hold_%0d got=%h exp=%h", i, brtype_pcpre, {2'b10, 32'h1C000100}); end
            checks++; if (pred_valid !== 1'b1) begin failures++; $display("FAIL stall_valid_%0d got=%b exp=1", i, pred_valid); end
        end
        flush = 1'b1;
        step();
        checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", pred_valid); end
        checks++; if (brtype_pcpre !== {2'b00, 32'h4}) begin failures++; $display("FAIL flush_brtype got=%h exp=%h", brtype_pcpre, {2'b00, 32'h4}); end
        flush = 1'b0; stall = 1'b0; if1_valid = 1'b1;
        pd_wr(32'h1C000010, 2'b00, 32'h0);
        if1_pc = 32'h1C000010; #1;
        checks++; if (pred_npc !== 32'h1C000014) begin failures++; $display("FAIL pd_remove got=%h exp=1c000014", pred_npc); end
    endtask

    task automatic test_async_reset;
        if1_pc = 32'h40;
        step();
        checks++; if (brtype_pcpre !== {2'b11, 32'h240}) begin failures++; $display("FAIL ar_setup got=%h exp=%h", brtype_pcpre, {2'b11, 32'h240}); end
        #2;
        rstn = 1'b0;
        ex_upd_en = 1'b1; ex_pc = 32'h1C; ex_type = 2'b10; ex_taken = 1'b1; ex_target = 32'h700;
        #1;
        checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", pred_valid); end
        checks++; if (brtype_pcpre !== 34'd0) begin failures++; $display("FAIL ar_brtype got=%h exp=0", brtype_pcpre); end
        step();
        ex_upd_en = 1'b0;
        rstn = 1'b1;
        #1;
        checks++; if (pred_npc !== 32'h44) begin failures++; $display("FAIL ar_miss got=%h exp=44", pred_npc); end
        if1_pc = 32'h1C; #1;
        checks++; if (pred_npc !== 32'h20) begin failures++; $display("FAIL ar_discard got=%h exp=20", pred_npc); end
    endtask

    initial begin
        test_reset();
        test_cold_lookup();
        test_pd_alloc();
        test_counter();
        test_collision();
        test_stall_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
